// File: rtl/shared_line_memory.sv
// shared_line_memory: line-wide backing store shared by NUM_PORTS requesters.
// Requests are arbitrated round-robin. Each granted access takes LATENCY
// cycles from the grant edge to a one-cycle ready pulse on the granted port.
// A single response cycle follows each access, and then the arbiter re-samples.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst_n      - asynchronous active-low reset
//   port_read  - per-port read request level
//   port_write - per-port write request level (wins over read)
//   port_addr  - per-port line address, port p at [p*ADDR_W +: ADDR_W]
//   port_wdata - per-port write line, port p at [p*LINE_W +: LINE_W]
//   port_rdata - per-port registered read line
//   port_ready - per-port one-cycle completion pulse
//   busy       - high while an access is in flight (ACCESS or RESP)
//   grant_idx  - index of the port currently or last served
module shared_line_memory #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          port_read,
  input  logic [NUM_PORTS-1:0]          port_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
  input  logic [NUM_PORTS*LINE_W-1:0]   port_wdata,
  output logic [NUM_PORTS*LINE_W-1:0]   port_rdata,
  output logic [NUM_PORTS-1:0]          port_ready,
  output logic                          busy,
  output logic [2:0]                    grant_idx
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [PW-1:0]         gnt;
  logic [PW-1:0]         rr;
  logic [PW-1:0]         sel;
  logic                  found;
  logic                  op_wr;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  ready_q;
  logic                  do_access;
  int unsigned           cand;

  logic [ADDR_W-1:0]     addr_a  [NUM_PORTS];
  logic [LINE_W-1:0]     wdata_a [NUM_PORTS];
  logic [LINE_W-1:0]     rdata_q [NUM_PORTS];
  logic [LINE_W-1:0]     mem     [1 << DEPTH_LOG2];

  assign req = port_read | port_write;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      addr_a[p]  = port_addr[p*ADDR_W +: ADDR_W];
      wdata_a[p] = port_wdata[p*LINE_W +: LINE_W];
    end
  end

  // Round-robin pick: first requesting port at or after rr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = 32'(rr) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        sel   = cand[PW-1:0];
      end
    end
  end

  assign do_access = (state == ACCESS) && (cnt == '0);

  // Array has no reset; since state resets asynchronously, an aborted access
  // can never reach do_access and so never commits.
  always_ff @(posedge clk) begin
    if (do_access && op_wr) mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt     <= '0;
      rr      <= '0;
      op_wr   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ready_q <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) rdata_q[p] <= '0;
    end else begin
      ready_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt     <= sel;
            idx_q   <= addr_a[sel][DEPTH_LOG2-1:0];
            wdata_q <= wdata_a[sel];
            op_wr   <= port_write[sel];
            cnt     <= CW'(LATENCY - 1);
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            rdata_q[gnt] <= op_wr ? wdata_q : mem[idx_q];
            ready_q[gnt] <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          rr    <= (gnt == PW'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      port_rdata[p*LINE_W +: LINE_W] = rdata_q[p];
    end
  end

  assign port_ready = ready_q;
  assign busy       = (state != IDLE);
  assign grant_idx  = 3'(gnt);

endmodule

// File: tb/tb_shared_line_memory.sv
// Directed bench for shared_line_memory with default parameters
// (2 ports, LATENCY 4, DEPTH_LOG2 10).
module tb_shared_line_memory;

  localparam int NP = 2;
  localparam int AW = 28;
  localparam int LW = 128;
  localparam int LAT = 4;

  logic              clk;
  logic              rst_n;
  logic [NP-1:0]     port_read;
  logic [NP-1:0]     port_write;
  logic [NP*AW-1:0]  port_addr;
  logic [NP*LW-1:0]  port_wdata;
  logic [NP*LW-1:0]  port_rdata;
  logic [NP-1:0]     port_ready;
  logic              busy;
  logic [2:0]        grant_idx;

  shared_line_memory #(
    .NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW), .DEPTH_LOG2(10), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .port_read(port_read), .port_write(port_write),
    .port_addr(port_addr), .port_wdata(port_wdata),
    .port_rdata(port_rdata), .port_ready(port_ready),
    .busy(busy), .grant_idx(grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [LW-1:0] rdata(input int p);
    return port_rdata[p*LW +: LW];
  endfunction

  task automatic set_port(input int p, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [LW-1:0] d);
    port_read[p]          = rd;
    port_write[p]         = wr;
    port_addr[p*AW +: AW] = a;
    port_wdata[p*LW +: LW] = d;
  endtask

  // Results of the last serve call: port order, cycle of ready relative
  // to the grant edge, and grant_idx sampled at the ready cycle.
  int ord [8];
  int when [8];
  int gidx [8];
  int multi;

  // Runs from IDLE with requests already driven until n ready pulses are
  // seen. A served port drops its request; with rearm it re-raises it one
  // cycle later.
  task automatic serve(input int n, input logic [NP-1:0] rearm);
    int cyc;
    int got;
    logic [NP-1:0] pend;
    logic [NP-1:0] srd;
    logic [NP-1:0] swr;
    cyc = 0; got = 0; pend = '0; srd = '0; swr = '0;
    multi = 0;
    while (got < n && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      for (int p = 0; p < NP; p++) begin
        if (pend[p]) begin
          port_read[p] = srd[p];
          port_write[p] = swr[p];
          pend[p] = 1'b0;
        end
      end
      if ($countones(port_ready) > 1) multi++;
      for (int p = 0; p < NP; p++) begin
        if (port_ready[p] && got < 8) begin
          ord[got] = p;
          when[got] = cyc - 1;
          gidx[got] = int'(grant_idx);
          got++;
          srd[p] = port_read[p];
          swr[p] = port_write[p];
          port_read[p] = 1'b0;
          port_write[p] = 1'b0;
          if (rearm[p]) pend[p] = 1'b1;
        end
      end
    end
    check("serve_count", 128'(got), 128'(n));
    port_read = '0;
    port_write = '0;
    // RESP cycle passes; ready must have dropped.
    @(posedge clk); #1;
    check("ready_drop", 128'(port_ready), 128'(0));
  endtask

  localparam logic [LW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] PAT_11 = {16{8'h11}};
  localparam logic [LW-1:0] PAT_22 = {16{8'h22}};
  localparam logic [LW-1:0] PAT_DB = {4{32'hDEADBEEF}};
  localparam logic [LW-1:0] PAT_AL = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    rst_n = 1'b0;
    port_read = '0; port_write = '0; port_addr = '0; port_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata0", rdata(0), '0);
    check("rst_rdata1", rdata(1), '0);
    check("rst_ready", 128'(port_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_grant", 128'(grant_idx), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Port0 write, then port1 read of the same line.
    set_port(0, 1'b0, 1'b1, 28'h10, PAT_A5);
    serve(1, 2'b00);
    check("wr_latency", 128'(when[0]), 128'(LAT));
    check("wr_port", 128'(ord[0]), 128'(0));
    check("wr_rdata0", rdata(0), PAT_A5);
    set_port(1, 1'b1, 1'b0, 28'h10, '0);
    serve(1, 2'b00);
    check("rd_latency", 128'(when[0]), 128'(LAT));
    check("rd_rdata1", rdata(1), PAT_A5);
    check("rd_rdata0_kept", rdata(0), PAT_A5);
    check("rd_grant", 128'(gidx[0]), 128'(1));

    // Simultaneous reads with pointer at 0.
    set_port(0, 1'b1, 1'b0, 28'h10, '0);
    set_port(1, 1'b1, 1'b0, 28'h10, '0);
    serve(2, 2'b00);
    check("sim_first", 128'(ord[0]), 128'(0));
    check("sim_t0", 128'(when[0]), 128'(LAT));
    check("sim_t1", 128'(when[1]), 128'(2*LAT + 2));
    check("sim_g0", 128'(gidx[0]), 128'(0));
    check("sim_g1", 128'(gidx[1]), 128'(1));
    check("sim_onehot", 128'(multi), 128'(0));

    // Both ports keep re-requesting: grants must alternate.
    set_port(0, 1'b1, 1'b0, 28'h10, '0);
    set_port(1, 1'b1, 1'b0, 28'h10, '0);
    serve(4, 2'b11);
    check("rr_o0", 128'(ord[0]), 128'(0));
    check("rr_o1", 128'(ord[1]), 128'(1));
    check("rr_o2", 128'(ord[2]), 128'(0));
    check("rr_o3", 128'(ord[3]), 128'(1));
    check("rr_t3", 128'(when[3]), 128'(4*LAT + 6));
    check("rr_onehot", 128'(multi), 128'(0));

    // Aliasing: 0x401 maps to the same index as 0x001.
    set_port(0, 1'b0, 1'b1, 28'h001, PAT_AL);
    serve(1, 2'b00);
    set_port(1, 1'b1, 1'b0, 28'h401, '0);
    serve(1, 2'b00);
    check("alias_rdata1", rdata(1), PAT_AL);

    // Reset during the ACCESS phase of a write aborts it.
    set_port(0, 1'b0, 1'b1, 28'h20, PAT_11);
    serve(1, 2'b00);
    set_port(0, 1'b0, 1'b1, 28'h20, PAT_22);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy", 128'(busy), 128'(1));
    check("abort_noready", 128'(port_ready), 128'(0));
    rst_n = 1'b0;
    port_read = '0; port_write = '0;
    #1;
    check("abort_busy_rst", 128'(busy), 128'(0));
    check("abort_rdata0_rst", rdata(0), '0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (port_ready != '0) seen++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (port_ready != '0) seen++;
      end
      check("abort_no_pulse", 128'(seen), 128'(0));
    end
    set_port(1, 1'b1, 1'b0, 28'h20, '0);
    serve(1, 2'b00);
    check("abort_old_data", rdata(1), PAT_11);

    // Read and write both high: treated as a write.
    set_port(1, 1'b1, 1'b1, 28'h30, PAT_DB);
    serve(1, 2'b00);
    check("rw_rdata1", rdata(1), PAT_DB);
    set_port(0, 1'b1, 1'b0, 28'h30, '0);
    serve(1, 2'b00);
    check("rw_readback0", rdata(0), PAT_DB);
    check("rw_grant", 128'(gidx[0]), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
